// File: rtl/button_event_unit.sv
// N-channel debounced button classifier (single/double/long) with a shared event FIFO on AHB-Lite.
// Define BUTTON_LONG_PRESS_EN to build in LONG-press (code 3) classification.
//
// state  | meaning
// IDLE   | released, waiting for a falling edge
// DB1    | debouncing the first press
// HELD   | first press accepted, button held
// WAIT   | released, double-click window running
// DB2    | debouncing a second press inside the window
// REL    | event emitted, waiting for release
module button_event_unit #(
  parameter int N_BUTTONS       = 2,
  parameter int DEBOUNCE_CYCLES = 900,
  parameter int CLICK_CYCLES    = 16000,
  parameter int LONG_CYCLES     = 32000,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic [31:0]          HADDR,
  input  logic [31:0]          HWDATA,
  input  logic                 HWRITE,
  input  logic                 HREADY,
  input  logic                 HSEL,
  input  logic [2:0]           HSIZE,
  input  logic [1:0]           HTRANS,
  input  logic [N_BUTTONS-1:0] Buttons,
  output logic [31:0]          HRDATA,
  output logic                 HREADYOUT,
  output logic                 IRQ
);

  localparam int TMAX = (CLICK_CYCLES > LONG_CYCLES) ? CLICK_CYCLES : LONG_CYCLES;
  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW   = $clog2(TMAX + 1);
  localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW   = PW + 1;
  localparam logic [DW-1:0] D_TC  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] C_TC  = TW'(CLICK_CYCLES - 1);
  localparam logic [TW-1:0] T_SAT = TW'(TMAX);
`ifdef BUTTON_LONG_PRESS_EN
  localparam logic [TW-1:0] L_TC  = TW'(LONG_CYCLES - 1);
`endif

  typedef enum logic [2:0] {S_IDLE, S_DB1, S_HELD, S_WAIT, S_DB2, S_REL} state_t;

  state_t               st_q   [N_BUTTONS];
  state_t               st_d   [N_BUTTONS];
  logic [DW-1:0]        dcnt_q [N_BUTTONS];
  logic [DW-1:0]        dcnt_d [N_BUTTONS];
  logic [TW-1:0]        tcnt_q [N_BUTTONS];
  logic [TW-1:0]        tcnt_d [N_BUTTONS];
  logic [1:0]           emit   [N_BUTTONS];
  logic [N_BUTTONS-1:0] btn_prev_q;
  logic [N_BUTTONS-1:0] fall;

  logic [N_BUTTONS-1:0] pend_q;
  logic [1:0]           pend_code_q [N_BUTTONS];
  logic                 ovf_q;
  logic                 push_v;
  logic [3:0]           push_ch;
  logic [1:0]           push_code;

  logic [5:0]           mem_q [FIFO_DEPTH];
  logic [PW-1:0]        wptr_q, rptr_q;
  logic [CW-1:0]        count_q;
  logic                 empty, full, pop;

  logic [2:0]           addr_q;
  logic                 wr_q;
  logic [1:0]           ctrl_q;
  logic                 clr_ovf;
  logic                 unused_ok;

  assign unused_ok = ^{HSIZE, HADDR[31:5], HADDR[1:0], HWDATA[31:2]};
  assign fall      = ~Buttons & btn_prev_q;
  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(FIFO_DEPTH));
  assign pop       = !wr_q && (addr_q == 3'd1) && !empty;
  assign clr_ovf   = wr_q && (addr_q == 3'd3) && HWDATA[0];
  assign HREADYOUT = 1'b1;
  assign IRQ       = ctrl_q[1] & ~empty;

  always_comb begin
    for (int i = 0; i < N_BUTTONS; i++) begin
      st_d[i]   = st_q[i];
      dcnt_d[i] = dcnt_q[i];
      tcnt_d[i] = (tcnt_q[i] == T_SAT) ? tcnt_q[i] : tcnt_q[i] + 1'b1;
      emit[i]   = 2'd0;
      if (!ctrl_q[0]) begin
        st_d[i]   = S_IDLE;
        dcnt_d[i] = '0;
        tcnt_d[i] = '0;
      end else begin
        case (st_q[i])
          S_IDLE: if (fall[i]) begin st_d[i] = S_DB1; dcnt_d[i] = '0; end
          S_DB1: begin
            if (Buttons[i]) st_d[i] = S_IDLE;
            else if (dcnt_q[i] == D_TC) begin st_d[i] = S_HELD; tcnt_d[i] = '0; end
            else dcnt_d[i] = dcnt_q[i] + 1'b1;
          end
          S_HELD: begin
            if (Buttons[i]) begin st_d[i] = S_WAIT; tcnt_d[i] = '0; end
`ifdef BUTTON_LONG_PRESS_EN
            else if (tcnt_q[i] == L_TC) begin emit[i] = 2'd3; st_d[i] = S_REL; end
`else
            else tcnt_d[i] = tcnt_q[i];
`endif
          end
          S_WAIT: begin
            if (fall[i]) begin st_d[i] = S_DB2; dcnt_d[i] = '0; end
            else if (tcnt_q[i] >= C_TC) begin emit[i] = 2'd1; st_d[i] = S_IDLE; end
          end
          S_DB2: begin
            if (dcnt_q[i] == D_TC) begin emit[i] = 2'd2; st_d[i] = S_REL; end
            else if (Buttons[i]) st_d[i] = S_WAIT;
            else if (tcnt_q[i] >= C_TC) begin
              // the second press restarts classification as a fresh first press
              emit[i] = 2'd1; st_d[i] = S_DB1; dcnt_d[i] = dcnt_q[i] + 1'b1;
            end else dcnt_d[i] = dcnt_q[i] + 1'b1;
          end
          S_REL: if (Buttons[i]) st_d[i] = S_IDLE;
          default: st_d[i] = S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      btn_prev_q <= '1;
      for (int i = 0; i < N_BUTTONS; i++) begin
        st_q[i] <= S_IDLE; dcnt_q[i] <= '0; tcnt_q[i] <= '0;
      end
    end else begin
      btn_prev_q <= Buttons;
      for (int i = 0; i < N_BUTTONS; i++) begin
        st_q[i] <= st_d[i]; dcnt_q[i] <= dcnt_d[i]; tcnt_q[i] <= tcnt_d[i];
      end
    end
  end

  // descending scan so the lowest-index occupied slot wins
  always_comb begin
    push_v = 1'b0; push_ch = '0; push_code = '0;
    if (!full) begin
      for (int i = N_BUTTONS - 1; i >= 0; i--) begin
        if (pend_q[i]) begin push_v = 1'b1; push_ch = 4'(i); push_code = pend_code_q[i]; end
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pend_q <= '0; ovf_q <= 1'b0;
      for (int i = 0; i < N_BUTTONS; i++) pend_code_q[i] <= 2'd0;
    end else begin
      if (clr_ovf) ovf_q <= 1'b0;
      for (int i = 0; i < N_BUTTONS; i++) begin
        if (push_v && push_ch == 4'(i)) pend_q[i] <= 1'b0;
        if (!ctrl_q[0]) pend_q[i] <= 1'b0;
        else if (emit[i] != 2'd0) begin
          if (pend_q[i]) ovf_q <= 1'b1;
          else begin pend_q[i] <= 1'b1; pend_code_q[i] <= emit[i]; end
        end
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wptr_q <= '0; rptr_q <= '0; count_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push_v) begin mem_q[wptr_q] <= {push_ch, push_code}; wptr_q <= wptr_q + 1'b1; end
      if (pop) rptr_q <= rptr_q + 1'b1;
      count_q <= count_q + CW'(push_v) - CW'(pop);
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_q <= 3'd7; wr_q <= 1'b0; ctrl_q <= 2'b01;
    end else begin
      if (HSEL && HREADY && HTRANS != 2'b00) begin addr_q <= HADDR[4:2]; wr_q <= HWRITE; end
      else begin addr_q <= 3'd7; wr_q <= 1'b0; end
      if (wr_q && addr_q == 3'd2) ctrl_q <= HWDATA[1:0];
    end
  end

  always_comb begin
    HRDATA = '0;
    if (!wr_q) begin
      case (addr_q)
        3'd0: HRDATA = {19'b0, 5'(count_q), 5'b0, ovf_q, full, !empty};
        3'd1: if (!empty) HRDATA = {1'b1, 19'b0, mem_q[rptr_q][5:2], 6'b0, mem_q[rptr_q][1:0]};
        3'd2: HRDATA = {30'b0, ctrl_q};
        default: HRDATA = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_button_event_unit.sv
// Scoreboard bench for button_event_unit: gesture-level reference model, read monitor compares HRDATA/IRQ.
`timescale 1ns/1ps
module tb_button_event_unit;
  localparam int NB = 2, DB = 16, CK = 120, LG = 300, FD = 4;
`ifdef BUTTON_LONG_PRESS_EN
  localparam int LONG_CODE = 3;
`else
  localparam int LONG_CODE = 1;
`endif

  logic          HCLK = 1'b0, HRESETn = 1'b0;
  logic [31:0]   HADDR = '0, HWDATA = '0, HRDATA;
  logic          HWRITE = 1'b0, HREADY = 1'b1, HSEL = 1'b0, HREADYOUT, IRQ;
  logic [2:0]    HSIZE = 3'b010;
  logic [1:0]    HTRANS = 2'b00;
  logic [NB-1:0] btn = '1;

  button_event_unit #(.N_BUTTONS(NB), .DEBOUNCE_CYCLES(DB), .CLICK_CYCLES(CK),
                      .LONG_CYCLES(LG), .FIFO_DEPTH(FD)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HWDATA(HWDATA), .HWRITE(HWRITE),
    .HREADY(HREADY), .HSEL(HSEL), .HSIZE(HSIZE), .HTRANS(HTRANS), .Buttons(btn),
    .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .IRQ(IRQ));

  always #5 HCLK = ~HCLK;

  int n_checks = 0, n_pass = 0;

  function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endfunction

  // reference model: event FIFO, per-channel one-entry pending slot, sticky overflow
  logic [31:0] mfifo[$];
  bit          mpend   [NB];
  logic [31:0] mpend_w [NB];
  bit          movf, m_en, m_irqen;

  function automatic void m_reset();
    mfifo.delete(); movf = 0; m_en = 1; m_irqen = 0;
    for (int i = 0; i < NB; i++) mpend[i] = 0;
  endfunction

  function automatic void m_event(int ch, int code);
    logic [31:0] w;
    w = 32'h8000_0000 | (32'(ch) << 8) | 32'(code);
    if (mpend[ch]) movf = 1;
    else if (mfifo.size() < FD) mfifo.push_back(w);
    else begin mpend[ch] = 1; mpend_w[ch] = w; end
  endfunction

  function automatic logic [31:0] m_pop();
    logic [31:0] w;
    if (mfifo.size() == 0) return 32'h0;
    w = mfifo.pop_front();
    for (int i = 0; i < NB; i++)
      if (mpend[i]) begin mfifo.push_back(mpend_w[i]); mpend[i] = 0; break; end
    return w;
  endfunction

  function automatic logic [31:0] m_status();
    logic [4:0] c;
    c = 5'(mfifo.size());
    return {19'b0, c, 5'b0, movf, mfifo.size() == FD, mfifo.size() != 0};
  endfunction

  typedef struct { logic [31:0] data; bit chk_irq; logic irq; logic [2:0] a; } exp_t;
  exp_t exp_q[$];

  function automatic void expect_read(logic [2:0] a);
    exp_t e;
    e.a = a; e.chk_irq = (a == 3'd0);
    e.irq = m_irqen && (mfifo.size() != 0);
    case (a)
      3'd0: e.data = m_status();
      3'd1: e.data = m_pop();
      3'd2: e.data = {30'b0, m_irqen, m_en};
      default: e.data = 32'h0;
    endcase
    exp_q.push_back(e);
  endfunction

  logic mon_rd = 1'b0;
  always @(posedge HCLK) mon_rd <= HSEL && HREADY && (HTRANS != 2'b00) && !HWRITE;

  always @(negedge HCLK) begin
    if (mon_rd) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_read: got %h expected no read", HRDATA);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check($sformatf("rdata_addr%0d", e.a), HRDATA, e.data);
        if (e.chk_irq) check("irq", {31'b0, IRQ}, {31'b0, e.irq});
      end
    end
  end

  task automatic rd(input logic [2:0] a);
    expect_read(a);
    HSEL = 1; HTRANS = 2'b10; HWRITE = 0; HADDR = {27'b0, a, 2'b0};
    @(negedge HCLK);
    HSEL = 0; HTRANS = 2'b00;
    @(negedge HCLK);
  endtask

  task automatic rd2_event();
    expect_read(3'd1);
    expect_read(3'd1);
    HSEL = 1; HTRANS = 2'b10; HWRITE = 0; HADDR = 32'h4;
    @(negedge HCLK);
    @(negedge HCLK);
    HSEL = 0; HTRANS = 2'b00;
    @(negedge HCLK);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    HSEL = 1; HTRANS = 2'b10; HWRITE = 1; HADDR = {27'b0, a, 2'b0};
    @(negedge HCLK);
    HSEL = 0; HTRANS = 2'b00; HWRITE = 0; HWDATA = d;
    @(negedge HCLK);
    if (a == 3'd2) begin
      m_en = d[0]; m_irqen = d[1];
      if (!d[0]) for (int i = 0; i < NB; i++) mpend[i] = 0;
    end
    if (a == 3'd3 && d[0]) movf = 0;
  endtask

  task automatic press(input int ch, input int len);
    btn[ch] = 1'b0;
    repeat (len) @(negedge HCLK);
    btn[ch] = 1'b1;
  endtask

  // kind: 0 glitch, 1 single, 2 double, 3 long hold
  task automatic gesture(input int ch, input int kind);
    case (kind)
      0: press(ch, $urandom_range(DB - 5, 1));
      1: press(ch, $urandom_range(60, DB + 5));
      2: begin
        press(ch, $urandom_range(50, DB + 5));
        repeat ($urandom_range(40, 10)) @(negedge HCLK);
        press(ch, $urandom_range(60, DB + 5));
      end
      default: press(ch, $urandom_range(LG + DB + 80, LG + DB + 20));
    endcase
    repeat (CK + 30) @(negedge HCLK);
    if (m_en) begin
      if (kind == 1) m_event(ch, 1);
      else if (kind == 2) m_event(ch, 2);
      else if (kind == 3) m_event(ch, LONG_CODE);
    end
  endtask

  initial begin
    int ch, kind;
    m_reset();
    repeat (4) @(negedge HCLK);
    check("reset_hreadyout", {31'b0, HREADYOUT}, 32'h1);
    check("reset_irq", {31'b0, IRQ}, 32'h0);
    check("reset_hrdata", HRDATA, 32'h0);
    HRESETn = 1'b1;
    @(negedge HCLK);
    rd(3'd0); rd(3'd1); rd(3'd2); rd(3'd5);

    wr(3'd2, 32'h3);
    rd(3'd2);
    gesture(0, 1);
    rd(3'd0); rd(3'd1); rd(3'd0);
    gesture(1, 2);
    rd(3'd1); rd(3'd1);
    gesture(0, 3);
    rd(3'd0); rd(3'd1);

    for (int i = 0; i < 6; i++) gesture(0, 1);
    wr(3'd0, 32'hFFFF_FFFF);
    rd(3'd0);
    rd2_event(); rd2_event();
    rd(3'd0);
    wr(3'd3, 32'h1);
    rd(3'd0); rd(3'd1); rd(3'd0);

    gesture(0, 0);
    wr(3'd2, 32'h2);
    gesture(0, 1);
    gesture(1, 2);
    wr(3'd2, 32'h3);
    rd(3'd0); rd(3'd1);

    for (int it = 0; it < 40; it++) begin
      ch = $urandom_range(NB - 1, 0);
      kind = $urandom_range(3, 0);
      gesture(ch, kind);
      case ($urandom_range(3, 0))
        0: rd(3'd1);
        1: begin rd(3'd0); rd(3'd1); end
        2: rd2_event();
        default: ;
      endcase
      if ($urandom_range(7, 0) == 0) wr(3'd3, 32'h1);
    end
    rd(3'd0);

    gesture(0, 1); gesture(1, 1);
    btn[0] = 1'b0;
    repeat (DB + 5) @(negedge HCLK);
    HRESETn = 1'b0;
    repeat (3) @(negedge HCLK);
    btn[0] = 1'b1;
    m_reset();
    check("midreset_irq", {31'b0, IRQ}, 32'h0);
    HRESETn = 1'b1;
    repeat (CK + 30) @(negedge HCLK);
    rd(3'd0); rd(3'd1); rd(3'd2);

    repeat (4) @(negedge HCLK);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
